// File: rtl/alu_iter.sv
// alu_iter: W-bit execute-stage ALU with iterative multiply and shifts.
// Ports: clk/rst, in_valid/in_ready + op/a/b request, out_valid/out_ready +
// result/carry/overflow/zero/illegal response.
module alu_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         illegal
);
  localparam int SW = $clog2(W);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  result_q, result_d;
  logic          carry_q, carry_d;
  logic          overflow_q, overflow_d;
  logic          zero_q, zero_d;
  logic          illegal_q, illegal_d;

  // Single-cycle datapath on the live inputs; used only on the accept cycle.
  logic          sub;
  logic [W-1:0]  b_eff;
  logic [W:0]    sum;
  logic          c_in_msb;
  logic          ovf;
  logic [W-1:0]  alu_res;
  logic          alu_c, alu_v, alu_ill;
  logic          is_shift;
  logic [SW-1:0] n;

  always_comb begin
    sub      = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
    b_eff    = sub ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    c_in_msb = a[W-1] ^ b_eff[W-1] ^ sum[W-1];
    ovf      = c_in_msb ^ sum[W];
    is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    n        = b[SW-1:0];
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_ill  = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD, OP_SUB: begin
        alu_res = sum[W-1:0];
        alu_c   = sum[W];
        alu_v   = ovf;
      end
      OP_SLT:  alu_res = {{(W-1){1'b0}}, sum[W-1] ^ ovf};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, ~sum[W]};
      // Shift by zero finishes here and returns a unchanged.
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // One iteration: MUL and SLL both walk opa left.
  logic [W-1:0] acc_step;
  logic [W-1:0] sh_next;
  logic [W-1:0] step_res;

  always_comb begin
    acc_step = acc_q + (opb_q[0] ? opa_q : '0);
    case (op_q)
      OP_SRL:  sh_next = opa_q >> 1;
      OP_SRA:  sh_next = {opa_q[W-1], opa_q[W-1:1]};
      default: sh_next = opa_q << 1;
    endcase
    step_res = (op_q == OP_MUL) ? acc_step : sh_next;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    illegal_d  = illegal_q;
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = op;
          opa_d = a;
          opb_d = b;
          acc_d = '0;
          if (op == OP_MUL) begin
            cnt_d   = SW'(W - 1);
            state_d = BUSY;
          end else if (is_shift && n != '0) begin
            cnt_d   = n - SW'(1);
            state_d = BUSY;
          end else begin
            result_d   = alu_res;
            carry_d    = alu_c;
            overflow_d = alu_v;
            zero_d     = (alu_res == '0);
            illegal_d  = alu_ill;
            state_d    = DONE;
          end
        end
      end
      BUSY: begin
        acc_d = acc_step;
        opa_d = sh_next;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == '0) begin
          result_d   = step_res;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          zero_d     = (step_res == '0);
          illegal_d  = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
    end
  end

  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;
  assign illegal  = illegal_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter (W=32).
// Driver pushes expectations; a negedge monitor pops and compares.
module tb_alu_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        carry, overflow, zero, illegal;

  alu_iter #(.W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic        c, v, z, il;
    int          t;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   seen = 0;
  int   rise = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !seen) begin
        seen = 1;
        rise = cyc;
      end
      if (out_valid && out_ready) begin
        seen = 0;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: out_valid=1 result=%h, want no output", result);
        end else begin
          e = sb.pop_front();
          if ({result, carry, overflow, zero, illegal} !== {e.res, e.c, e.v, e.z, e.il}) begin
            fails++;
            $display("FAIL %s: got r=%h c=%b v=%b z=%b il=%b, want r=%h c=%b v=%b z=%b il=%b",
                     e.nm, result, carry, overflow, zero, illegal,
                     e.res, e.c, e.v, e.z, e.il);
          end
          tests++;
          if (rise != e.t) begin
            fails++;
            $display("FAIL %s_lat: out_valid at cycle %0d, want %0d", e.nm, rise, e.t);
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] er, input logic ec, input logic ev,
                       input logic ez, input logic ei, input int lat,
                       input bit push, input string nm);
    exp_t e;
    int w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: in_ready=0, want 1 within 200 cycles", nm);
      return;
    end
    in_valid = 1'b1;
    op = o;
    a = xa;
    b = xb;
    if (push) begin
      e.nm = nm; e.res = er; e.c = ec; e.v = ev; e.z = ez; e.il = ei;
      e.t = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 4'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int lowc;
    int bad;
    logic [35:0] held;

    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, result, carry, overflow, zero, illegal} !== {2'b10, 32'h0, 4'h0}) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b r=%h flags=%b%b%b%b, want rdy=1 vld=0 r=0 flags=0000",
               in_ready, out_valid, result, carry, overflow, zero, illegal);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    issue(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0, 0, 1, 1, "add_ovf");
    issue(4'b0010, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 0, 1, 0, 1, 1, "add_carry");
    issue(4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 0, 1, 1, "sub_borrow");
    issue(4'b0110, 32'd7, 32'd5, 32'd2, 1, 0, 0, 0, 1, 1, "sub_noborrow");
    issue(4'b0101, 32'hFFFFFFFF, 32'h1, 32'd1, 0, 0, 0, 0, 1, 1, "slt");
    issue(4'b0111, 32'hFFFFFFFF, 32'h1, 32'd0, 0, 0, 1, 0, 1, 1, "sltu");
    issue(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1, 1, "and");
    issue(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 0, 1, 1, "or");
    issue(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 0, 1, 1, "xor");
    drain();

    issue(4'b1000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0, 0, 0, 33, 1, "mul_neg");
    lowc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!in_ready) lowc++;
      if (out_valid) break;
    end
    tests++;
    if (lowc != 33) begin
      fails++;
      $display("FAIL mul_busy: in_ready low for %0d cycles, want 33", lowc);
    end
    drain();
    issue(4'b1000, 32'h10000, 32'h10000, 32'h0, 0, 0, 1, 0, 33, 1, "mul_zero");
    drain();

    issue(4'b1011, 32'h80000000, 32'd4, 32'hF8000000, 0, 0, 0, 0, 5, 1, "sra");
    issue(4'b1010, 32'h80000000, 32'd4, 32'h08000000, 0, 0, 0, 0, 5, 1, "srl");
    issue(4'b1001, 32'h12345678, 32'h20, 32'h12345678, 0, 0, 0, 0, 1, 1, "sll_zero");
    issue(4'b1001, 32'h1, 32'd31, 32'h80000000, 0, 0, 0, 0, 32, 1, "sll_31");
    issue(4'b1001, 32'h3, 32'h24, 32'h30, 0, 0, 0, 0, 5, 1, "sll_mask");
    drain();

    issue(4'b1111, 32'd5, 32'd6, 32'h0, 0, 0, 1, 1, 1, 1, "illegal");
    issue(4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1, 1, "after_illegal");
    drain();

    out_ready = 1'b0;
    issue(4'b0010, 32'd1, 32'd1, 32'd2, 0, 0, 0, 0, 1, 1, "bp_add");
    @(negedge clk);
    held = {result, carry, overflow, zero, illegal};
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || {result, carry, overflow, zero, illegal} !== held) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    issue(4'b1000, 32'd3, 32'd5, 32'd15, 0, 0, 0, 0, 33, 0, "mul_rst");
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, result, carry, overflow, zero, illegal} !== {2'b10, 32'h0, 4'h0}) begin
      fails++;
      $display("FAIL mid_rst: rdy=%b vld=%b r=%h flags=%b%b%b%b, want rdy=1 vld=0 r=0 flags=0000",
               in_ready, out_valid, result, carry, overflow, zero, illegal);
    end
    repeat (40) @(posedge clk);
    #1;
    issue(4'b0010, 32'd10, 32'd20, 32'd30, 0, 0, 0, 0, 1, 1, "after_rst");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, W-bit sequential ALU for the execute stage. It covers the integer operations that the single-bit ALU slices already provide: AND, OR, XOR, ADD, SUB, SLT and SLTU. It adds iterative multiply and barrel-free shifts, and puts a valid/ready handshake on both sides. Single-cycle operations return in one clock; MUL and the shifts hold the block busy for a bounded number of cycles, stalling the pipeline through `in_ready`.

## Interface
- `W`, default 32: datapath width; power of two, at least 4. `SW = log2(W)` is the shift-amount width.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  block can accept a request; high only in IDLE
- `op`  in  4  operation code, listed under Operation
- `a`  in  W  operand A; also the shift source
- `b`  in  W  operand B; `b[SW-1:0]` is the shift amount
- `out_valid`  out  1  result and flags valid
- `out_ready`  in  1  consumer accepts the result
- `result`  out  W  operation result
- `carry`  out  1  carry-out for ADD/SUB, otherwise 0
- `overflow`  out  1  signed overflow for ADD/SUB, otherwise 0
- `zero`  out  1  `result == 0`, valid for all ops
- `illegal`  out  1  unrecognised op code

## Operation
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0100 XOR
  - 0110 SUB
  - 0101 SLT (signed)
  - 0111 SLTU
  - 1000 MUL (low W bits of A×B)
  - 1001 SLL
  - 1010 SRL
  - 1011 SRA
  - all other codes are illegal
- Operands and op are captured on the accept cycle (`in_valid && in_ready`). Later input changes have no effect on the operation in flight.
- ADD computes A+B. SUB computes A+~B+1.
  - `carry` is the carry-out of bit W-1. For SUB, `carry = 1` means no borrow (A ≥ B unsigned).
  - `overflow = carry_into_msb ^ carry_out_msb`.
- SLT: `result = {W-1 zeros, sum_msb ^ overflow}` of A-B. SLTU: `result = {W-1 zeros, ~carry}` of A-B. Both report `carry = 0` and `overflow = 0`.
- MUL uses shift-add, one multiplier bit per cycle, for W iterations. Signed and unsigned products have identical low bits. `carry = 0`, `overflow = 0`.
- Shifts move one bit position per cycle, for `n = b[SW-1:0]` iterations. SRA replicates `a[W-1]`. If `n = 0`, the result is `a` and the op completes as a single-cycle op.
- An illegal op gives `result = 0`, `illegal = 1`, `zero = 1`, single-cycle latency.
- FSM states:
  - IDLE: `in_ready = 1`. On accept, go to BUSY for MUL or for a shift with n>0; otherwise compute and go to DONE.
  - BUSY: an iteration counter counts down. When it expires, go to DONE.
  - DONE: `out_valid = 1`; all outputs are held stable. Go to IDLE when `out_ready = 1`.
- No new request is accepted in BUSY or DONE.

## Timing
- Reset values: state IDLE, `in_ready = 1`, `out_valid = 0`, `result = 0`, `carry = 0`, `overflow = 0`, `zero = 0`, `illegal = 0`. The iteration counter and accumulators are cleared.
- Latency, with the accept at cycle T:
  - single-cycle op: `out_valid` at T+1
  - MUL: `out_valid` at T+W+1 (T+33 for W=32)
  - shift by n>0: `out_valid` at T+n+1
- `out_ready` may already be high when `out_valid` rises. In that case the result is consumed in that cycle and `in_ready` is high the next cycle. Best-case throughput is one single-cycle op every 2 cycles.
- Backpressure: while `out_valid && !out_ready`, `result` and all flags are held bit-stable for any number of cycles.
- `rst` asserted in any state, including mid-MUL or mid-shift, forces the reset values on the next edge. The partial operation is discarded and no `out_valid` is produced for it.
- `in_valid` while `in_ready = 0` is ignored; the source must hold it.
- Flags are registered with `result` and qualify only while `out_valid` is high.

## Test plan
- ADD, W=32: `a=0x7FFFFFFF`, `b=1` → `result=0x80000000`, `overflow=1`, `carry=0`, `zero=0`, `out_valid` at T+1. Then `a=0xFFFFFFFF`, `b=1` → `result=0`, `carry=1`, `zero=1`, `overflow=0`.
- SUB/SLT/SLTU: `a=5`, `b=7`, SUB → `0xFFFFFFFE`, `carry=0`. With `a=0xFFFFFFFF`, `b=1`: SLT → 1 and SLTU → 0.
- MUL: `a=7`, `b=0xFFFFFFFD` → `0xFFFFFFEB`, `out_valid` exactly at T+33, `in_ready` low T+1..T+33. Then `a=0x10000`, `b=0x10000` → `0`, `zero=1`.
- Shifts: SRA `a=0x80000000`, `b=4` → `0xF8000000` at T+5. SRL same operands → `0x08000000`. SLL with `b=0x20` (amount 0) → `a` at T+1.
- Backpressure and reset: hold `out_ready=0` for 10 cycles → outputs stable and `in_ready=0`. Separately, assert `rst` at T+10 of a MUL → all outputs at reset values, `in_ready=1` the next cycle, no `out_valid`.
- Illegal op 1111 → `result=0`, `illegal=1`, `zero=1` at T+1. The next legal op clears `illegal`.
